// File: rtl/serial_add_pkg.sv
// Shared types and limits for the bit-serial adder sequencer.
//   sa_state_t : controller state encoding (IDLE, RUN, DONE)
//   W_MAX      : widest legal operand width
package serial_add_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} sa_state_t;

  localparam int W_MAX = 64;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Operand/result handshake bundle for serial_add_ctrl.
//   in_valid/in_ready   : operand handshake (a_in, b_in, cin_in, sub_in)
//   out_valid/out_ready : result handshake (sum_out, cout_out)
//   busy                : sequencer is occupied (RUN or DONE)
// Optional macro SERIAL_ADD_SUB_EN adds the sub_in request line.
// master = operand source / result consumer, slave = the sequencer.
interface serial_add_ctrl_if #(
  parameter int W = 4
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin_in;
`ifdef SERIAL_ADD_SUB_EN
  logic         sub_in;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum_out;
  logic         cout_out;
  logic         busy;

  modport master (
`ifdef SERIAL_ADD_SUB_EN
    output sub_in,
`endif
    output in_valid, a_in, b_in, cin_in, out_ready,
    input  in_ready, out_valid, sum_out, cout_out, busy
  );

  modport slave (
`ifdef SERIAL_ADD_SUB_EN
    input  sub_in,
`endif
    input  in_valid, a_in, b_in, cin_in, out_ready,
    output in_ready, out_valid, sum_out, cout_out, busy
  );
endinterface

// File: rtl/serial_add_ctrl_fa.sv
// full_add: the single 1-bit full adder cell time-shared by serial_add_ctrl.
//   a, b, cin : addend bits and carry-in
//   sum, cout : sum bit and carry-out
module full_add (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sequencer. Captures two W-bit operands,
// then feeds one bit pair per clock (LSB first) through a shared full_add cell,
// and presents the W-bit sum plus carry-out on a valid/ready result port.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, aborts any operation in progress
//   bus  : serial_add_ctrl_if.slave (operand/result handshakes, busy)
// Optional macro SERIAL_ADD_SUB_EN: sub_in selects a-b (b inverted, cin forced 1).
//
// state | meaning
// IDLE  | in_ready high, waiting for operands
// RUN   | one bit per clock through full_add, W cycles
// DONE  | out_valid high, holding result until out_ready
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int W = 4
) (
  input  logic              clk,
  input  logic              rst,
  serial_add_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(W) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0]       r_state;
  logic [W-1:0]     r_a_sh;
  logic [W-1:0]     r_b_sh;
  logic [W-1:0]     r_sum_sh;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic [W-1:0]     r_sum_out;
  logic             r_cout_out;

  logic             w_fa_sum;
  logic             w_fa_cout;
  logic [W-1:0]     w_sum_next;
  logic [W-1:0]     w_b_cap;
  logic             w_cin_cap;

  full_add u_fa (
    .a    (r_a_sh[0]),
    .b    (r_b_sh[0]),
    .cin  (r_carry),
    .sum  (w_fa_sum),
    .cout (w_fa_cout)
  );

  // New sum bit enters at the MSB; after W shifts bit 0 has reached the LSB.
  generate
    if (W == 1) begin : g_sum_w1
      assign w_sum_next = w_fa_sum;
    end else begin : g_sum_wn
      assign w_sum_next = {w_fa_sum, r_sum_sh[W-1:1]};
    end
  endgenerate

`ifdef SERIAL_ADD_SUB_EN
  // Two's-complement subtract: a + ~b + 1. cin_in is ignored when subtracting.
  assign w_b_cap   = bus.sub_in ? ~bus.b_in : bus.b_in;
  assign w_cin_cap = bus.sub_in ? 1'b1      : bus.cin_in;
`else
  assign w_b_cap   = bus.b_in;
  assign w_cin_cap = bus.cin_in;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_a_sh     <= '0;
      r_b_sh     <= '0;
      r_sum_sh   <= '0;
      r_carry    <= 1'b0;
      r_cnt      <= '0;
      r_sum_out  <= '0;
      r_cout_out <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_a_sh   <= bus.a_in;
            r_b_sh   <= w_b_cap;
            r_carry  <= w_cin_cap;
            r_sum_sh <= '0;
            r_cnt    <= '0;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_sum_sh <= w_sum_next;
          r_carry  <= w_fa_cout;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_LAST) begin
            r_sum_out  <= w_sum_next;
            r_cout_out <= w_fa_cout;
            r_state    <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.busy      = (r_state == S_RUN) || (r_state == S_DONE);
  assign bus.sum_out   = r_sum_out;
  assign bus.cout_out  = r_cout_out;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: a W=4 instance checked every cycle against
// a job-level model (accept time, due time, expected sum), plus a W=1 instance
// checked with literal expectations.
module tb_serial_add_ctrl;

  localparam int W = 4;

  logic clk;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  serial_add_ctrl_if #(.W(W)) bus4 ();
  serial_add_ctrl_if #(.W(1)) bus1 ();

  serial_add_ctrl #(.W(W)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));
  serial_add_ctrl #(.W(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- job-level model of the W=4 instance ----------------
  int           cyc = 0;
  bit           chk_en = 0;
  bit           m_busy = 0;
  int           m_done_at = 0;
  logic [W-1:0] m_exp_sum;
  logic         m_exp_cout;
  logic [W-1:0] m_last_sum = '0;
  logic         m_last_cout = 1'b0;

  always @(posedge clk) begin
    logic [W:0]   res;
    logic [W-1:0] bb;
    logic         c;
    logic         sub;
    cyc++;
    if (rst) begin
      m_busy      = 0;
      m_last_sum  = '0;
      m_last_cout = 1'b0;
      chk_en      = 1;
    end else if (m_busy) begin
      if (cyc == m_done_at) begin
        m_last_sum  = m_exp_sum;
        m_last_cout = m_exp_cout;
      end else if (cyc > m_done_at && bus4.out_ready) begin
        m_busy = 0;
      end
    end else if (bus4.in_valid) begin
      sub = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      sub = bus4.sub_in;
`endif
      bb  = sub ? ~bus4.b_in : bus4.b_in;
      c   = sub ? 1'b1 : bus4.cin_in;
      res = {1'b0, bus4.a_in} + {1'b0, bb} + {{W{1'b0}}, c};
      m_exp_sum  = res[W-1:0];
      m_exp_cout = res[W];
      m_busy     = 1;
      m_done_at  = cyc + W;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", bus4.out_valid, (m_busy && cyc >= m_done_at));
      chk("in_ready",  bus4.in_ready,  !m_busy);
      chk("busy",      bus4.busy,      m_busy);
      chk("sum_out",   bus4.sum_out,   m_last_sum);
      chk("cout_out",  bus4.cout_out,  m_last_cout);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send4(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic sub);
    bus4.a_in     = a;
    bus4.b_in     = b;
    bus4.cin_in   = cin;
`ifdef SERIAL_ADD_SUB_EN
    bus4.sub_in   = sub;
`endif
    bus4.in_valid = 1'b1;
    step();
    bus4.in_valid = 1'b0;
`ifndef SERIAL_ADD_SUB_EN
    if (sub) $display("note: sub request ignored in add-only build");
`endif
  endtask

  task automatic wait_valid4(input int max, output int lat);
    lat = 0;
    while (!bus4.out_valid && lat < max) begin
      step();
      lat++;
    end
    if (!bus4.out_valid) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_valid4: out_valid not seen within %0d cycles", max);
    end
  endtask

  task automatic drain4();
    bus4.out_ready = 1'b1;
    step();
    bus4.out_ready = 1'b0;
  endtask

  task automatic add_check(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input logic sub,
                           input logic [W-1:0] exp_sum, input logic exp_cout);
    int lat;
    send4(a, b, cin, sub);
    wait_valid4(20, lat);
    chk({name, "_lat"},  lat,           W);
    chk({name, "_sum"},  bus4.sum_out,  exp_sum);
    chk({name, "_cout"}, bus4.cout_out, exp_cout);
    drain4();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bus4.in_valid = 0; bus4.a_in = '0; bus4.b_in = '0; bus4.cin_in = 0; bus4.out_ready = 0;
    bus1.in_valid = 0; bus1.a_in = '0; bus1.b_in = '0; bus1.cin_in = 0; bus1.out_ready = 0;
`ifdef SERIAL_ADD_SUB_EN
    bus4.sub_in = 0;
    bus1.sub_in = 0;
`endif
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    chk("rst_in_ready",  bus4.in_ready,  1'b1);
    chk("rst_out_valid", bus4.out_valid, 1'b0);
    chk("rst_busy",      bus4.busy,      1'b0);
    chk("rst_sum",       bus4.sum_out,   4'h0);
    chk("rst_cout",      bus4.cout_out,  1'b0);

    // basic adds and wrap-around
    add_check("t1", 4'h3, 4'h5, 1'b0, 1'b0, 4'h8, 1'b0);
    add_check("t2", 4'hF, 4'h1, 1'b0, 1'b0, 4'h0, 1'b1);
    add_check("ta", 4'hA, 4'h7, 1'b1, 1'b0, 4'h2, 1'b1);
    add_check("tb", 4'h0, 4'h0, 1'b1, 1'b0, 4'h1, 1'b0);
    add_check("tc", 4'hF, 4'hF, 1'b1, 1'b0, 4'hF, 1'b1);
    chk("idle_keeps_sum", bus4.sum_out, 4'hF);

    // back-pressure: result held for 5 cycles, then immediate re-accept
    send4(4'h6, 4'h6, 1'b0, 1'b0);
    wait_valid4(20, lat);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_sum",      bus4.sum_out,   4'hC);
      chk("bp_cout",     bus4.cout_out,  1'b0);
      chk("bp_in_ready", bus4.in_ready,  1'b0);
      chk("bp_valid",    bus4.out_valid, 1'b1);
    end
    drain4();
    chk("bp_release_in_ready", bus4.in_ready, 1'b1);
    add_check("bp_next", 4'h9, 4'h4, 1'b0, 1'b0, 4'hD, 1'b0);

    // W=1 instance: one cycle from accept to result
    bus1.a_in = 1'b1; bus1.b_in = 1'b1; bus1.cin_in = 1'b1; bus1.in_valid = 1'b1;
    step();
    bus1.in_valid = 1'b0;
    chk("w1_busy_run", bus1.busy, 1'b1);
    step();
    chk("w1_valid", bus1.out_valid, 1'b1);
    chk("w1_sum",   bus1.sum_out,   1'b1);
    chk("w1_cout",  bus1.cout_out,  1'b1);
    bus1.out_ready = 1'b1;
    step();
    bus1.out_ready = 1'b0;
    chk("w1_idle", bus1.in_ready, 1'b1);

    // reset in the middle of RUN aborts with no output
    send4(4'h7, 4'h7, 1'b0, 1'b0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_valid",    bus4.out_valid, 1'b0);
    chk("abort_in_ready", bus4.in_ready,  1'b1);
    chk("abort_sum",      bus4.sum_out,   4'h0);
    for (int i = 0; i < W + 2; i++) step();
    chk("abort_no_result", bus4.out_valid, 1'b0);
    add_check("t4", 4'h1, 4'h1, 1'b0, 1'b0, 4'h2, 1'b0);

    // in_valid held with changing operands during RUN: first pair only
    bus4.a_in = 4'h3; bus4.b_in = 4'h4; bus4.cin_in = 1'b0; bus4.in_valid = 1'b1;
    step();
    for (int i = 0; i < W; i++) begin
      bus4.a_in   = 4'(i + 8);
      bus4.b_in   = 4'(i * 3 + 1);
      bus4.cin_in = 1'b1;
      step();
    end
    bus4.in_valid = 1'b0;
    chk("t5_valid", bus4.out_valid, 1'b1);
    chk("t5_sum",   bus4.sum_out,   4'h7);
    chk("t5_cout",  bus4.cout_out,  1'b0);
    drain4();

`ifdef SERIAL_ADD_SUB_EN
    add_check("sub1", 4'h2, 4'h5, 1'b0, 1'b1, 4'hD, 1'b0);
    add_check("sub2", 4'h5, 4'h2, 1'b0, 1'b1, 4'h3, 1'b1);
`endif

    step();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
